voice_alloc: RTL
================

// Module: voice_alloc
// PURPOSE
// - MIDI note-event to synth-voice allocator; producer side of the per-voice key interface (note_on / cur_key_adr / cur_key_val).
// - Sits between the MIDI decoder and the pitch/envelope engines; owns per-voice gates and last-key/voice assignment.
// - Picks a voice per note-on: retrigger same key, else lowest free, else steal oldest. Strobes the key into downstream per-voice key registers.
// PARAMETERS
// - VOICES   8  number of synth voices (power of 2, >=2)
// - V_WIDTH  3  log2(VOICES); width of voice index
// PORTS
// - reg_clk       in   1        sole clock
// - reset         in   1        synchronous, active-high reset
// - ev_valid      in   1        note event present
// - ev_ready      out  1        allocator can accept event (high only in IDLE, all_notes_off low)
// - ev_note_on    in   1        1=note-on, 0=note-off
// - ev_key        in   7        MIDI key number
// - ev_vel        in   7        MIDI velocity; note-on with vel 0 == note-off
// - all_notes_off in   1        clear every gate (sampled in IDLE only)
// - gate          out  VOICES   per-voice key-held flags
// - cur_key_adr   out  V_WIDTH  voice index being written
// - cur_key_val   out  8        {1'b0,key} for that voice
// - cur_vel       out  7        velocity for that voice
// - note_on       out  1        one-cycle strobe; downstream latches on its rising edge
// - voice_steal   out  1        one-cycle pulse, coincident with note_on, when a held voice was stolen
// - ev_dropped    out  1        one-cycle pulse when a note-on found no voice
// BEHAVIOUR
// - Reset: state IDLE, gate=0, cur_key_adr=0, cur_key_val=0, cur_vel=0, note_on/voice_steal/ev_dropped=0, rank[i]=i. ev_ready=0 during the reset cycle and 1 on the next cycle.
// - FSM: IDLE -> SCAN -> COMMIT -> STROBE -> HOLD -> IDLE.
//   - A note-off or a drop goes COMMIT -> IDLE.
// - IDLE: if all_notes_off, then gate<=0 and ev_ready=0 (takes priority over the event). Else ev_valid&ev_ready latches the event; go to SCAN.
// - SCAN: VOICES cycles, one voice per cycle, index 0 upward. Records:
//   - match = first v with gate[v] && key[v]==ev_key
//   - free  = lowest v with !gate[v]
//   - oldest = v with rank[v]==VOICES-1
// - COMMIT, note-on (vel!=0), target = match, else free, else oldest (steal only with the macro):
//   - gate[t]<=1, key[t]<=ev_key.
//   - cur_key_adr/cur_key_val/cur_vel <= t/{0,key}/vel.
//   - Rank update: rank[t]<=0; every v with rank[v]<old rank[t] increments. The ranks stay a permutation and cannot wrap.
// - COMMIT, note-off: if match exists then gate[match]<=0, else ignore. No strobe; ranks unchanged.
// - STROBE: note_on=1 (and voice_steal=1 if stolen). HOLD: note_on=0. cur_* outputs are held stable from COMMIT through HOLD.
// - Latency, with accept at cycle 0: note_on high at cycle VOICES+2. Next ev_ready at VOICES+4 (on) or VOICES+2 (off/drop).
// - Rules:
//   - Retrigger of a held key reuses its voice and re-strobes.
//   - ev_* inputs are ignored outside IDLE.
//   - Reset in any state aborts the event; note_on is 0 on the cycle after reset is sampled.
// CONFIGURATION
// - VOICE_STEAL_EN defined: a note-on with all voices held steals the oldest-rank voice and pulses voice_steal.
// - VOICE_STEAL_EN undefined: such a note-on pulses ev_dropped at COMMIT; gate/rank/cur_* unchanged; voice_steal tied 0.
// STRUCTURE
// - voice_alloc_pkg holds:
//   - the FSM state enum (IDLE, SCAN, COMMIT, STROBE, HOLD)
//   - key_t (7-bit) and vel_t (7-bit)
//   - constant NO_VOICE flag encoding for scan results
// - Sub-module voice_age_rank owns the rank array:
//   - inputs: touch, idx
//   - outputs: oldest idx, rank[] readback for scan
// TESTING (VOICES=8)
// - Reset, then note-on key 60 vel 100 -> note_on at cycle 10, cur_key_adr=0, cur_key_val=60, cur_vel=100, gate=8'h01.
// - Note-ons 60..67 -> gate=8'hFF. Then key 72:
//   - steal on: voice 0 reused, voice_steal=1, cur_key_val=72.
//   - steal off: ev_dropped=1, no note_on, gate=8'hFF.
// - Note-off 62 -> gate bit2 cleared, no note_on, ev_ready back at cycle 10. Then note-on 70 -> cur_key_adr=2.
// - Note-on key 61 vel 0 while 61 held on voice 1 -> gate[1]=0, no strobe. Retrigger held 60 -> cur_key_adr=0, rank[0]=0.
// - all_notes_off together with ev_valid in IDLE -> gate=0, event not accepted (ev_ready=0) that cycle.
// - Reset asserted during STROBE -> note_on=0 next cycle, gate=0, ranks = index, ev_ready=1 after release.

Source files
------------

// File: rtl/voice_alloc_pkg.sv
// voice_alloc_pkg
// Shared types and constants for the voice allocator:
//   state_e / S_*  : allocator FSM state encoding
//   key_t, vel_t   : 7-bit MIDI key number and velocity
//   NO_VOICE       : flag bit value marking an empty scan result
//   voice_found()  : helper that decodes the flag bit of a scan result
package voice_alloc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SCAN   = 3'd1,
    ST_COMMIT = 3'd2,
    ST_STROBE = 3'd3,
    ST_HOLD   = 3'd4
  } state_e;

  // Plain constants so the state register can stay a logic vector.
  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_SCAN   = ST_SCAN;
  localparam logic [2:0] S_COMMIT = ST_COMMIT;
  localparam logic [2:0] S_STROBE = ST_STROBE;
  localparam logic [2:0] S_HOLD   = ST_HOLD;

  typedef logic [6:0] key_t;
  typedef logic [6:0] vel_t;

  // Scan results are {flag, index}; flag == NO_VOICE means nothing was found.
  localparam logic NO_VOICE = 1'b1;

  function automatic logic voice_found(input logic flag);
    return flag != NO_VOICE;
  endfunction

endpackage

// File: rtl/voice_alloc_if.sv
// voice_alloc_if
// Event side (MIDI decoder -> allocator) and per-voice key side
// (allocator -> pitch/envelope engines) of the voice allocator.
//   master : allocator view (accepts events, drives gates and key strobes)
//   slave  : decoder/engine view
// Signals:
//   ev_valid, ev_ready, ev_note_on, ev_key, ev_vel, all_notes_off
//   gate, cur_key_adr, cur_key_val, cur_vel, note_on, voice_steal, ev_dropped
interface voice_alloc_if #(
  parameter int VOICES  = 8,
  parameter int V_WIDTH = 3
);
  import voice_alloc_pkg::*;

  logic               ev_valid;
  logic               ev_ready;
  logic               ev_note_on;
  key_t               ev_key;
  vel_t               ev_vel;
  logic               all_notes_off;

  logic [VOICES-1:0]  gate;
  logic [V_WIDTH-1:0] cur_key_adr;
  logic [7:0]         cur_key_val;
  vel_t               cur_vel;
  logic               note_on;
  logic               voice_steal;
  logic               ev_dropped;

  modport master (
    input  ev_valid, ev_note_on, ev_key, ev_vel, all_notes_off,
    output ev_ready, gate, cur_key_adr, cur_key_val, cur_vel,
    output note_on, voice_steal, ev_dropped
  );

  modport slave (
    output ev_valid, ev_note_on, ev_key, ev_vel, all_notes_off,
    input  ev_ready, gate, cur_key_adr, cur_key_val, cur_vel,
    input  note_on, voice_steal, ev_dropped
  );

endinterface

// File: rtl/voice_age_rank.sv
// voice_age_rank
// Recency rank per voice: 0 = most recently assigned, VOICES-1 = oldest.
// The ranks always form a permutation of 0..VOICES-1.
// Ports:
//   reg_clk, reset : clock, synchronous active-high reset (rank[i] = i)
//   touch_i, idx_i : make voice idx_i the newest
//   rd_idx_i       : voice whose rank is read back
//   rd_rank_o      : rank of voice rd_idx_i
module voice_age_rank #(
  parameter int VOICES  = 8,
  parameter int V_WIDTH = 3
) (
  input  logic               reg_clk,
  input  logic               reset,
  input  logic               touch_i,
  input  logic [V_WIDTH-1:0] idx_i,
  input  logic [V_WIDTH-1:0] rd_idx_i,
  output logic [V_WIDTH-1:0] rd_rank_o
);

  logic [V_WIDTH-1:0] rank_q [VOICES];
  logic [V_WIDTH-1:0] old_rank;

  assign old_rank  = rank_q[idx_i];
  assign rd_rank_o = rank_q[rd_idx_i];

  // Only ranks younger than the touched voice age by one, so the oldest
  // possible rank is never exceeded and no wrap can occur.
  always_ff @(posedge reg_clk) begin
    if (reset) begin
      for (int v = 0; v < VOICES; v++) rank_q[v] <= V_WIDTH'(v);
    end else if (touch_i) begin
      for (int v = 0; v < VOICES; v++) begin
        if (V_WIDTH'(v) == idx_i)     rank_q[v] <= '0;
        else if (rank_q[v] < old_rank) rank_q[v] <= rank_q[v] + 1'b1;
      end
    end
  end

endmodule

// File: rtl/voice_alloc.sv
// voice_alloc
// MIDI note-event to synth-voice allocator. Per note-on: retrigger the voice
// already holding the key, else the lowest free voice, else (optionally)
// steal the oldest voice. The chosen key is strobed to the per-voice key
// registers downstream via cur_key_adr/cur_key_val/cur_vel and note_on.
// Build option: VOICE_STEAL_EN enables stealing; without it a note-on that
// finds every voice held pulses ev_dropped and changes nothing.
// Ports:
//   reg_clk : sole clock
//   reset   : synchronous, active-high
//   bus     : voice_alloc_if.master (event handshake and voice key outputs)
//
// state  | meaning
// IDLE   | ready for an event; all_notes_off clears every gate
// SCAN   | one voice per cycle: record match, lowest free, oldest
// COMMIT | apply note-on/note-off decision to gates, keys, ranks, cur_*
// STROBE | note_on (and voice_steal) high
// HOLD   | note_on low, cur_* still stable
module voice_alloc
  import voice_alloc_pkg::*;
#(
  parameter int VOICES  = 8,
  parameter int V_WIDTH = 3
) (
  input logic reg_clk,
  input logic reset,
  voice_alloc_if.master bus
);

  logic [2:0]         state_q, state_d;
  logic [V_WIDTH-1:0] scan_idx_q;
  logic               ev_on_q;
  key_t               ev_key_q;
  vel_t               ev_vel_q;
  logic [V_WIDTH:0]   match_q, free_q;
  logic [V_WIDTH-1:0] oldest_q;
  logic [VOICES-1:0]  gate_q;
  key_t               key_q [VOICES];
  logic [V_WIDTH-1:0] cur_key_adr_q;
  key_t               cur_key_q;
  vel_t               cur_vel_q;
  logic               note_on_q, voice_steal_q;

  logic [V_WIDTH-1:0] rank_rd;
  logic               accept;
  logic               has_match, has_free;
  logic               assign_c, release_c, stolen_c, drop_c;
  logic [V_WIDTH-1:0] target_c;

  localparam logic [V_WIDTH:0] NONE = {NO_VOICE, {V_WIDTH{1'b0}}};

  voice_age_rank #(.VOICES(VOICES), .V_WIDTH(V_WIDTH)) u_rank (
    .reg_clk  (reg_clk),
    .reset    (reset),
    .touch_i  (assign_c),
    .idx_i    (target_c),
    .rd_idx_i (scan_idx_q),
    .rd_rank_o(rank_rd)
  );

  assign bus.ev_ready = (state_q == S_IDLE) && !reset && !bus.all_notes_off;
  assign accept       = bus.ev_valid && bus.ev_ready;

  // Commit decision, only active in COMMIT.
  always_comb begin
    has_match = voice_found(match_q[V_WIDTH]);
    has_free  = voice_found(free_q[V_WIDTH]);
    target_c  = '0;
    assign_c  = 1'b0;
    release_c = 1'b0;
    stolen_c  = 1'b0;
    drop_c    = 1'b0;
    if (state_q == S_COMMIT) begin
      if (ev_on_q) begin
        if (has_match) begin
          target_c = match_q[V_WIDTH-1:0];
          assign_c = 1'b1;
        end else if (has_free) begin
          target_c = free_q[V_WIDTH-1:0];
          assign_c = 1'b1;
        end else begin
`ifdef VOICE_STEAL_EN
          target_c = oldest_q;
          assign_c = 1'b1;
          stolen_c = 1'b1;
`else
          drop_c   = 1'b1;
`endif
        end
      end else if (has_match) begin
        target_c  = match_q[V_WIDTH-1:0];
        release_c = 1'b1;
      end
    end
  end

`ifndef VOICE_STEAL_EN
  logic unused_oldest;
  assign unused_oldest = ^oldest_q;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_SCAN;
      S_SCAN:   if (scan_idx_q == V_WIDTH'(VOICES - 1)) state_d = S_COMMIT;
      S_COMMIT: state_d = assign_c ? S_STROBE : S_IDLE;
      S_STROBE: state_d = S_HOLD;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge reg_clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      scan_idx_q    <= '0;
      ev_on_q       <= 1'b0;
      ev_key_q      <= '0;
      ev_vel_q      <= '0;
      match_q       <= NONE;
      free_q        <= NONE;
      oldest_q      <= '0;
      gate_q        <= '0;
      for (int v = 0; v < VOICES; v++) key_q[v] <= '0;
      cur_key_adr_q <= '0;
      cur_key_q     <= '0;
      cur_vel_q     <= '0;
      note_on_q     <= 1'b0;
      voice_steal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      note_on_q     <= assign_c;
      voice_steal_q <= stolen_c;

      if (state_q == S_IDLE && bus.all_notes_off) gate_q <= '0;

      if (accept) begin
        // Velocity 0 note-on is treated as note-off from here on.
        ev_on_q    <= bus.ev_note_on && (bus.ev_vel != '0);
        ev_key_q   <= bus.ev_key;
        ev_vel_q   <= bus.ev_vel;
        scan_idx_q <= '0;
        match_q    <= NONE;
        free_q     <= NONE;
      end

      if (state_q == S_SCAN) begin
        scan_idx_q <= scan_idx_q + 1'b1;
        if (!voice_found(match_q[V_WIDTH]) && gate_q[scan_idx_q] &&
            key_q[scan_idx_q] == ev_key_q)
          match_q <= {~NO_VOICE, scan_idx_q};
        if (!voice_found(free_q[V_WIDTH]) && !gate_q[scan_idx_q])
          free_q <= {~NO_VOICE, scan_idx_q};
        if (rank_rd == V_WIDTH'(VOICES - 1)) oldest_q <= scan_idx_q;
      end

      if (assign_c) begin
        gate_q[target_c] <= 1'b1;
        key_q[target_c]  <= ev_key_q;
        cur_key_adr_q    <= target_c;
        cur_key_q        <= ev_key_q;
        cur_vel_q        <= ev_vel_q;
      end
      if (release_c) gate_q[target_c] <= 1'b0;
    end
  end

  assign bus.gate        = gate_q;
  assign bus.cur_key_adr = cur_key_adr_q;
  assign bus.cur_key_val = {1'b0, cur_key_q};
  assign bus.cur_vel     = cur_vel_q;
  assign bus.note_on     = note_on_q;
  assign bus.voice_steal = voice_steal_q;
  assign bus.ev_dropped  = drop_c;

endmodule
